// File: rtl/hazard_pkg.sv
// Shared types for the issue-side hazard controller: FSM states, the control
// bundle driven onto the pipeline registers, and the load-use detect term.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LOAD_USE = 2'd1,
    MDU_WAIT = 2'd2,
    MEM_WAIT = 2'd3
  } state_e;

  localparam logic [4:0] REG_X0 = 5'd0;

  typedef struct packed {
    logic pc_we;
    logic ifid_we;
    logic ifid_flush;
    logic idex_flush;
    logic hold;
  } ctrl_t;

  localparam ctrl_t CTRL_PASS     = '{pc_we: 1'b1, ifid_we: 1'b1, ifid_flush: 1'b0, idex_flush: 1'b0, hold: 1'b0};
  localparam ctrl_t CTRL_HOLD     = '{pc_we: 1'b0, ifid_we: 1'b0, ifid_flush: 1'b0, idex_flush: 1'b0, hold: 1'b1};
  localparam ctrl_t CTRL_BUBBLE   = '{pc_we: 1'b0, ifid_we: 1'b0, ifid_flush: 1'b0, idex_flush: 1'b1, hold: 1'b0};
  localparam ctrl_t CTRL_REDIRECT = '{pc_we: 1'b1, ifid_we: 1'b1, ifid_flush: 1'b1, idex_flush: 1'b1, hold: 1'b0};

  // x0 is hardwired, so a load targeting it never creates a dependency.
  function automatic logic lu_hazard(
    input logic       mem_read,
    input logic [4:0] ex_rd,
    input logic [4:0] rs1,
    input logic [4:0] rs2,
    input logic       use_rs1,
    input logic       use_rs2
  );
    return mem_read && (ex_rd != REG_X0) &&
           ((use_rs1 && (ex_rd == rs1)) || (use_rs2 && (ex_rd == rs2)));
  endfunction

endpackage

// File: rtl/hazard_perf_cnt.sv
// Free-running 32-bit event counters for stall cycles, IF/ID flushes and
// load-use events; wrap at 2^32, cleared by the synchronous active-low reset.
module hazard_perf_cnt (
  input  logic        clk,
  input  logic        rst,
  input  logic        pc_we_i,
  input  logic        ifid_flush_i,
  input  logic        lu_event_i,
  output logic [31:0] perf_stall_cyc_o,
  output logic [31:0] perf_flush_cnt_o,
  output logic [31:0] perf_lu_cnt_o
);

  logic [31:0] stall_q, stall_d;
  logic [31:0] flush_q, flush_d;
  logic [31:0] lu_q, lu_d;

  always_comb begin
    stall_d = stall_q + {31'd0, ~pc_we_i};
    flush_d = flush_q + {31'd0, ifid_flush_i};
    lu_d    = lu_q + {31'd0, lu_event_i};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_q <= '0;
      flush_q <= '0;
      lu_q    <= '0;
    end else begin
      stall_q <= stall_d;
      flush_q <= flush_d;
      lu_q    <= lu_d;
    end
  end

  assign perf_stall_cyc_o = stall_q;
  assign perf_flush_cnt_o = flush_q;
  assign perf_lu_cnt_o    = lu_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Issue-side hazard control: load-use bubbles, MUL/DIV busy with timeout,
// memory wait and branch redirect. Perf counters under HAZARD_PERF_CNT_EN.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MULDIV_TIMEOUT  = 64,
  parameter int LOAD_USE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] ID_RS1,
  input  logic [4:0] ID_RS2,
  input  logic       ID_use_rs1,
  input  logic       ID_use_rs2,
  input  logic       ID_EX_MemRead,
  input  logic [4:0] ID_EX_Rd,
  input  logic       EX_branch_taken,
  input  logic       EX_muldiv_start,
  input  logic       muldiv_done,
  input  logic       IM_stall,
  input  logic       DM_stall,
  output logic       PC_Write,
  output logic       IF_ID_Write,
  output logic       IF_ID_Flush,
  output logic       ID_EX_Flush,
  output logic       Pipe_Hold,
  output logic       mdu_err
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] perf_stall_cyc,
  output logic [31:0] perf_flush_cnt,
  output logic [31:0] perf_lu_cnt
`endif
);

  localparam int TW = $clog2(MULDIV_TIMEOUT) + 1;
  localparam logic [TW-1:0] MDU_LIMIT = TW'(MULDIV_TIMEOUT);
  localparam logic [1:0]    LU_LOAD   = 2'(LOAD_USE_CYCLES - 1);

  state_e        state_q, state_d;
  logic [TW-1:0] mdu_cnt_q, mdu_cnt_d, mdu_cnt_inc;
  logic [1:0]    lu_cnt_q, lu_cnt_d;
  logic          mdu_err_q, mdu_err_d;

  ctrl_t  run_ctrl, ctrl;
  state_e run_next;
  logic   run_lu;
  logic   take_run;
  logic   lu_event;
  logic   mem_stall;
  logic   lu_hit;

  assign mem_stall   = IM_stall || DM_stall;
  assign lu_hit      = lu_hazard(ID_EX_MemRead, ID_EX_Rd, ID_RS1, ID_RS2, ID_use_rs1, ID_use_rs2);
  assign mdu_cnt_inc = mdu_cnt_q + 1'b1;

  // Issue decision used in RUN and in every cycle that releases a wait state.
  always_comb begin
    run_ctrl = CTRL_PASS;
    run_next = RUN;
    run_lu   = 1'b0;
    if (mem_stall) begin
      run_ctrl = CTRL_HOLD;
      run_next = MEM_WAIT;
    end else if (EX_muldiv_start) begin
      run_ctrl = CTRL_HOLD;
      run_next = MDU_WAIT;
    end else if (EX_branch_taken) begin
      run_ctrl = CTRL_REDIRECT;
    end else if (lu_hit) begin
      run_ctrl = CTRL_BUBBLE;
      run_lu   = 1'b1;
      if (LOAD_USE_CYCLES > 1) begin
        run_next = LOAD_USE;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    mdu_cnt_d = mdu_cnt_q;
    lu_cnt_d  = lu_cnt_q;
    mdu_err_d = mdu_err_q;
    ctrl      = CTRL_PASS;
    take_run  = 1'b0;
    lu_event  = 1'b0;

    case (state_q)
      RUN: take_run = 1'b1;
      LOAD_USE: begin
        if (lu_cnt_q != 2'd0) begin
          ctrl     = CTRL_BUBBLE;
          lu_cnt_d = lu_cnt_q - 2'd1;
        end else begin
          take_run = 1'b1;
        end
      end
      MDU_WAIT: begin
        if (muldiv_done) begin
          take_run = 1'b1;
        end else if (mdu_cnt_inc == MDU_LIMIT) begin
          mdu_err_d = 1'b1;
          take_run  = 1'b1;
        end else begin
          ctrl      = CTRL_HOLD;
          mdu_cnt_d = mdu_cnt_inc;
        end
      end
      MEM_WAIT: begin
        if (mem_stall) begin
          ctrl = CTRL_HOLD;
        end else begin
          take_run = 1'b1;
        end
      end
      default: take_run = 1'b1;
    endcase

    if (take_run) begin
      ctrl     = run_ctrl;
      state_d  = run_next;
      lu_event = run_lu;
      if (run_next == MDU_WAIT) begin
        mdu_cnt_d = '0;
      end
      if (run_lu) begin
        lu_cnt_d = LU_LOAD;
      end
    end

    // Reset cycles present a free-running pipe regardless of inputs.
    if (!rst) begin
      ctrl     = CTRL_PASS;
      lu_event = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= RUN;
      mdu_cnt_q <= '0;
      lu_cnt_q  <= '0;
      mdu_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mdu_cnt_q <= mdu_cnt_d;
      lu_cnt_q  <= lu_cnt_d;
      mdu_err_q <= mdu_err_d;
    end
  end

  assign PC_Write    = ctrl.pc_we;
  assign IF_ID_Write = ctrl.ifid_we;
  assign IF_ID_Flush = ctrl.ifid_flush;
  assign ID_EX_Flush = ctrl.idex_flush;
  assign Pipe_Hold   = ctrl.hold;
  assign mdu_err     = mdu_err_q;

`ifdef HAZARD_PERF_CNT_EN
  hazard_perf_cnt u_perf (
    .clk              (clk),
    .rst              (rst),
    .pc_we_i          (ctrl.pc_we),
    .ifid_flush_i     (ctrl.ifid_flush),
    .lu_event_i       (lu_event),
    .perf_stall_cyc_o (perf_stall_cyc),
    .perf_flush_cnt_o (perf_flush_cnt),
    .perf_lu_cnt_o    (perf_lu_cnt)
  );
`else
  logic perf_unused;
  assign perf_unused = lu_event;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios plus randomized traffic checked
// against a cycle-level behavioural model of the stall/flush rules.
module tb_hazard_ctrl;

  localparam int TIMEOUT = 64;
  localparam int LU_CYC  = 1;

  localparam logic [4:0] E_PASS   = 5'b11000;
  localparam logic [4:0] E_HOLD   = 5'b00001;
  localparam logic [4:0] E_BUBBLE = 5'b00010;
  localparam logic [4:0] E_REDIR  = 5'b11110;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [4:0] ID_RS1, ID_RS2, ID_EX_Rd;
  logic       ID_use_rs1, ID_use_rs2, ID_EX_MemRead;
  logic       EX_branch_taken, EX_muldiv_start, muldiv_done, IM_stall, DM_stall;
  logic       PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, Pipe_Hold, mdu_err;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] perf_stall_cyc, perf_flush_cnt, perf_lu_cnt;
`endif

  int total = 0;
  int bad   = 0;

  hazard_ctrl #(.MULDIV_TIMEOUT(TIMEOUT), .LOAD_USE_CYCLES(LU_CYC)) dut (
    .clk(clk), .rst(rst),
    .ID_RS1(ID_RS1), .ID_RS2(ID_RS2), .ID_use_rs1(ID_use_rs1), .ID_use_rs2(ID_use_rs2),
    .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_Rd(ID_EX_Rd),
    .EX_branch_taken(EX_branch_taken), .EX_muldiv_start(EX_muldiv_start),
    .muldiv_done(muldiv_done), .IM_stall(IM_stall), .DM_stall(DM_stall),
    .PC_Write(PC_Write), .IF_ID_Write(IF_ID_Write), .IF_ID_Flush(IF_ID_Flush),
    .ID_EX_Flush(ID_EX_Flush), .Pipe_Hold(Pipe_Hold), .mdu_err(mdu_err)
`ifdef HAZARD_PERF_CNT_EN
    , .perf_stall_cyc(perf_stall_cyc), .perf_flush_cnt(perf_flush_cnt), .perf_lu_cnt(perf_lu_cnt)
`endif
  );

  // {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, Pipe_Hold}
  function automatic logic [4:0] outs();
    return {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, Pipe_Hold};
  endfunction

  task automatic idle();
    rst = 1'b1;
    ID_RS1 = 5'd0; ID_RS2 = 5'd0; ID_use_rs1 = 1'b0; ID_use_rs2 = 1'b0;
    ID_EX_MemRead = 1'b0; ID_EX_Rd = 5'd0;
    EX_branch_taken = 1'b0; EX_muldiv_start = 1'b0; muldiv_done = 1'b0;
    IM_stall = 1'b0; DM_stall = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    step(); idle(); rst = 1'b0;
    step(); rst = 1'b1;
  endtask

  task automatic set_load(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic u1, input logic u2);
    ID_EX_MemRead = 1'b1; ID_EX_Rd = rd; ID_RS1 = rs1; ID_RS2 = rs2;
    ID_use_rs1 = u1; ID_use_rs2 = u2;
  endtask

  // ---------------- behavioural reference model ----------------
  int       m_lu_left;
  bit       m_in_mdu;
  int       m_mdu_age;
  bit       m_mem_wait;
  bit       m_err;
  int unsigned m_stall_cyc, m_flush_cnt, m_lu_cnt;

  task automatic model_cycle(output logic [4:0] exp);
    bit issue;
    bit lu;
    exp = E_PASS;
    if (!rst) begin
      m_lu_left = 0; m_in_mdu = 0; m_mdu_age = 0; m_mem_wait = 0; m_err = 0;
      m_stall_cyc = 0; m_flush_cnt = 0; m_lu_cnt = 0;
      return;
    end
    issue = 1;
    if (m_lu_left > 0) begin
      exp = E_BUBBLE; m_lu_left--; issue = 0;
    end else if (m_in_mdu) begin
      m_mdu_age++;
      if (muldiv_done) m_in_mdu = 0;
      else if (m_mdu_age >= TIMEOUT) begin m_in_mdu = 0; m_err = 1; end
      else begin exp = E_HOLD; issue = 0; end
    end else if (m_mem_wait) begin
      if (IM_stall || DM_stall) begin exp = E_HOLD; issue = 0; end
      else m_mem_wait = 0;
    end
    if (issue) begin
      lu = ID_EX_MemRead && (ID_EX_Rd != 0) &&
           ((ID_use_rs1 && ID_EX_Rd == ID_RS1) || (ID_use_rs2 && ID_EX_Rd == ID_RS2));
      if (IM_stall || DM_stall) begin exp = E_HOLD; m_mem_wait = 1; end
      else if (EX_muldiv_start) begin exp = E_HOLD; m_in_mdu = 1; m_mdu_age = 0; end
      else if (EX_branch_taken) exp = E_REDIR;
      else if (lu) begin exp = E_BUBBLE; m_lu_left = LU_CYC - 1; m_lu_cnt++; end
    end
    if (!exp[4]) m_stall_cyc++;
    if (exp[2])  m_flush_cnt++;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    for (int i = 0; i < 4; i++) begin
      step();
      rst = 1'b0;
      IM_stall = 1'($urandom_range(0, 1)); DM_stall = 1'($urandom_range(0, 1));
      EX_muldiv_start = 1'($urandom_range(0, 1)); EX_branch_taken = 1'($urandom_range(0, 1));
      set_load(5'd7, 5'd7, 5'd7, 1'b1, 1'b1);
      @(negedge clk);
      total++;
      if (outs() !== E_PASS) begin
        bad++; $display("FAIL reset_outs[%0d] got=%b exp=%b", i, outs(), E_PASS);
      end
      if (i > 0) begin
        total++;
        if (mdu_err !== 1'b0) begin bad++; $display("FAIL reset_mdu_err got=%b exp=0", mdu_err); end
      end
    end
    step(); idle();
  endtask

  task automatic test_load_use();
    do_reset();
    step(); set_load(5'd5, 5'd5, 5'd9, 1'b1, 1'b0);
    @(negedge clk); total++;
    if (outs() !== E_BUBBLE) begin bad++; $display("FAIL lu_rs1_stall got=%b exp=%b", outs(), E_BUBBLE); end
    step(); idle();
    @(negedge clk); total++;
    if (outs() !== E_PASS) begin bad++; $display("FAIL lu_rs1_release got=%b exp=%b", outs(), E_PASS); end
    step(); set_load(5'd12, 5'd3, 5'd12, 1'b1, 1'b1);
    @(negedge clk); total++;
    if (outs() !== E_BUBBLE) begin bad++; $display("FAIL lu_rs2_stall got=%b exp=%b", outs(), E_BUBBLE); end
    step(); set_load(5'd12, 5'd12, 5'd12, 1'b0, 1'b0);
    @(negedge clk); total++;
    if (outs() !== E_PASS) begin bad++; $display("FAIL lu_unused_src got=%b exp=%b", outs(), E_PASS); end
    step(); idle();
  endtask

  task automatic test_rd_zero();
    do_reset();
    step(); set_load(5'd0, 5'd0, 5'd0, 1'b1, 1'b1);
    @(negedge clk); total++;
    if (outs() !== E_PASS) begin bad++; $display("FAIL rd_zero got=%b exp=%b", outs(), E_PASS); end
    step(); idle();
  endtask

  task automatic test_branch_lu();
    do_reset();
    step(); set_load(5'd5, 5'd5, 5'd0, 1'b1, 1'b0); EX_branch_taken = 1'b1;
    @(negedge clk); total++;
    if (outs() !== E_REDIR) begin bad++; $display("FAIL branch_lu got=%b exp=%b", outs(), E_REDIR); end
    step(); idle();
    @(negedge clk); total++;
    if (outs() !== E_PASS) begin bad++; $display("FAIL branch_lu_after got=%b exp=%b", outs(), E_PASS); end
  endtask

  task automatic test_mdu();
    int held;
    do_reset();
    held = 0;
    step(); EX_muldiv_start = 1'b1;
    @(negedge clk);
    if (outs() === E_HOLD) held++;
    for (int c = 1; c < 5; c++) begin
      step(); idle(); EX_branch_taken = 1'b1;
      @(negedge clk);
      if (outs() === E_HOLD) held++;
    end
    total++;
    if (held != 5) begin bad++; $display("FAIL mdu_hold_cycles got=%0d exp=5", held); end
    step(); idle(); muldiv_done = 1'b1;
    @(negedge clk); total++;
    if (outs() !== E_PASS) begin bad++; $display("FAIL mdu_release got=%b exp=%b", outs(), E_PASS); end
    step(); idle();
    @(negedge clk); total++;
    if (outs() !== E_PASS || mdu_err !== 1'b0) begin
      bad++; $display("FAIL mdu_after got=%b err=%b exp=%b err=0", outs(), mdu_err, E_PASS);
    end
  endtask

  task automatic test_mdu_timeout();
    int held;
    do_reset();
    held = 0;
    step(); EX_muldiv_start = 1'b1;
    @(negedge clk);
    if (outs() === E_HOLD) held++;
    for (int c = 1; c < TIMEOUT; c++) begin
      step(); idle();
      @(negedge clk);
      if (outs() === E_HOLD) held++;
    end
    total++;
    if (held != TIMEOUT) begin bad++; $display("FAIL mdu_to_hold got=%0d exp=%0d", held, TIMEOUT); end
    step(); idle();
    @(negedge clk); total++;
    if (outs() !== E_PASS || mdu_err !== 1'b0) begin
      bad++; $display("FAIL mdu_to_release got=%b err=%b exp=%b err=0", outs(), mdu_err, E_PASS);
    end
    for (int c = 0; c < 10; c++) step();
    @(negedge clk); total++;
    if (mdu_err !== 1'b1) begin bad++; $display("FAIL mdu_err_sticky got=%b exp=1", mdu_err); end
    do_reset();
    @(negedge clk); total++;
    if (mdu_err !== 1'b0) begin bad++; $display("FAIL mdu_err_clear got=%b exp=0", mdu_err); end
  endtask

  task automatic test_mem_stall();
    int held;
    do_reset();
    held = 0;
    for (int c = 0; c < 3; c++) begin
      step(); idle(); DM_stall = 1'b1;
      @(negedge clk);
      if (outs() === E_HOLD) held++;
    end
    total++;
    if (held != 3) begin bad++; $display("FAIL mem_hold_cycles got=%0d exp=3", held); end
    step(); idle();
    @(negedge clk); total++;
    if (outs() !== E_PASS) begin bad++; $display("FAIL mem_release got=%b exp=%b", outs(), E_PASS); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    step(); EX_muldiv_start = 1'b1;
    for (int c = 0; c < 3; c++) begin step(); idle(); end
    @(negedge clk); total++;
    if (outs() !== E_HOLD) begin bad++; $display("FAIL mid_pre_hold got=%b exp=%b", outs(), E_HOLD); end
    step(); rst = 1'b0;
    @(negedge clk); total++;
    if (outs() !== E_PASS) begin bad++; $display("FAIL mid_in_reset got=%b exp=%b", outs(), E_PASS); end
    step(); rst = 1'b1;
    @(negedge clk); total++;
    if (outs() !== E_PASS) begin bad++; $display("FAIL mid_after_reset got=%b exp=%b", outs(), E_PASS); end
`ifdef HAZARD_PERF_CNT_EN
    total++;
    if (perf_stall_cyc !== 0 || perf_flush_cnt !== 0 || perf_lu_cnt !== 0) begin
      bad++; $display("FAIL perf_clear got=%0d/%0d/%0d exp=0/0/0", perf_stall_cyc, perf_flush_cnt, perf_lu_cnt);
    end
`endif
  endtask

  task automatic test_random();
    logic [4:0] exp;
    logic       exp_err;
    int         shown;
    int         done_pct;
    shown = 0;
    step(); idle(); rst = 1'b0;
    @(negedge clk); model_cycle(exp);
    for (int c = 0; c < 4000; c++) begin
      done_pct = (c < 2000) ? 15 : 1;
      step();
      rst             = ($urandom_range(0, 199) != 0);
      IM_stall        = ($urandom_range(0, 99) < 3);
      DM_stall        = ($urandom_range(0, 99) < 4);
      EX_muldiv_start = ($urandom_range(0, 99) < 3);
      muldiv_done     = ($urandom_range(0, 99) < done_pct);
      EX_branch_taken = ($urandom_range(0, 99) < 15);
      ID_EX_MemRead   = ($urandom_range(0, 99) < 40);
      ID_EX_Rd        = 5'($urandom_range(0, 3));
      ID_RS1          = 5'($urandom_range(0, 3));
      ID_RS2          = 5'($urandom_range(0, 3));
      ID_use_rs1      = ($urandom_range(0, 99) < 70);
      ID_use_rs2      = ($urandom_range(0, 99) < 70);
      @(negedge clk);
      exp_err = m_err;
      total++;
      if (mdu_err !== exp_err) begin
        bad++;
        if (shown < 20) begin shown++; $display("FAIL rand_mdu_err cyc=%0d got=%b exp=%b", c, mdu_err, exp_err); end
      end
`ifdef HAZARD_PERF_CNT_EN
      total++;
      if (perf_stall_cyc !== m_stall_cyc || perf_flush_cnt !== m_flush_cnt || perf_lu_cnt !== m_lu_cnt) begin
        bad++;
        if (shown < 20) begin
          shown++;
          $display("FAIL rand_perf cyc=%0d got=%0d/%0d/%0d exp=%0d/%0d/%0d", c, perf_stall_cyc,
                   perf_flush_cnt, perf_lu_cnt, m_stall_cyc, m_flush_cnt, m_lu_cnt);
        end
      end
`endif
      model_cycle(exp);
      total++;
      if (outs() !== exp) begin
        bad++;
        if (shown < 20) begin shown++; $display("FAIL rand_outs cyc=%0d got=%b exp=%b", c, outs(), exp); end
      end
    end
    step(); idle();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    test_reset();
    test_load_use();
    test_rd_zero();
    test_branch_lu();
    test_mdu();
    test_mdu_timeout();
    test_mem_stall();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline control block for the 5-stage RV32 core; the issue-side counterpart of the EX forwarding path.
- Forwarding resolves hazards by bypassing data. This block resolves the hazards bypassing cannot cover: load-use, multi-cycle MUL/DIV busy, memory wait and taken-branch redirect.
- Drives PC/IF_ID write enables and the IF_ID/ID_EX flush signals through a small FSM.

Parameters:
- MULDIV_TIMEOUT, 64, max cycles waiting for muldiv_done before mdu_err; counter width is clog2(MULDIV_TIMEOUT)+1.
- LOAD_USE_CYCLES, 1, bubble cycles inserted per load-use hazard (1..3).

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous reset, active-low
- ID_RS1  in  5  rs1 of the instruction in ID
- ID_RS2  in  5  rs2 of the instruction in ID
- ID_use_rs1  in  1  ID instruction reads rs1
- ID_use_rs2  in  1  ID instruction reads rs2
- ID_EX_MemRead  in  1  instruction in EX is a load
- ID_EX_Rd  in  5  rd of the instruction in EX
- EX_branch_taken  in  1  branch/jump resolved taken in EX (redirect)
- EX_muldiv_start  in  1  MUL/DIV instruction entering execution
- muldiv_done  in  1  MUL/DIV result valid (one-cycle pulse)
- IM_stall  in  1  instruction memory not ready
- DM_stall  in  1  data memory not ready
- PC_Write  out  1  PC update enable
- IF_ID_Write  out  1  IF/ID register enable
- IF_ID_Flush  out  1  IF/ID register clear
- ID_EX_Flush  out  1  ID/EX bubble insert
- Pipe_Hold  out  1  freeze EX/MEM and MEM/WB
- mdu_err  out  1  sticky MUL/DIV timeout flag

Behaviour:
- Reset (rst==0 at posedge):
  - state=RUN, counters=0, mdu_err=0.
  - Outputs during reset: PC_Write=1, IF_ID_Write=1, flushes=0, Pipe_Hold=0.
- Hazard term: lu_hazard = ID_EX_MemRead && ID_EX_Rd!=0 && ((ID_use_rs1 && ID_EX_Rd==ID_RS1) || (ID_use_rs2 && ID_EX_Rd==ID_RS2)).
- States: RUN, LOAD_USE, MDU_WAIT, MEM_WAIT.
- RUN:
  - Outputs follow combinational priority: memory stall > MDU start > branch > load-use.
  - IM_stall||DM_stall: Pipe_Hold=1, PC_Write=0, IF_ID_Write=0. Next state MEM_WAIT.
  - EX_muldiv_start: Pipe_Hold=1, PC_Write=0, IF_ID_Write=0. Next state MDU_WAIT, timeout counter cleared.
  - EX_branch_taken: IF_ID_Flush=1, ID_EX_Flush=1, PC_Write=1. Stays in RUN; the redirect penalty is 2 cycles, handled combinationally.
  - lu_hazard: PC_Write=0, IF_ID_Write=0, ID_EX_Flush=1. Next state LOAD_USE with bubble counter=LOAD_USE_CYCLES-1.
  - Branch and load-use in the same cycle: branch wins and no load-use stall is taken (the ID instruction is being flushed anyway).
- LOAD_USE:
  - PC_Write=0, IF_ID_Write=0, ID_EX_Flush=1 while counter!=0; decrement each cycle.
  - counter==0: outputs as in RUN and return to RUN.
  - With LOAD_USE_CYCLES=1 this state is never entered and the bubble is exactly 1 cycle.
- MDU_WAIT:
  - Pipe_Hold=1, PC_Write=0, IF_ID_Write=0; counter increments.
  - muldiv_done: release (outputs as RUN) in the same cycle, return to RUN.
  - Counter reaches MULDIV_TIMEOUT without done: set mdu_err, force release, return to RUN.
  - EX_branch_taken is ignored in this state; the branch is held in EX until release.
- MEM_WAIT: hold as in the RUN memory-stall case while IM_stall||DM_stall; when both drop, return to RUN with outputs as RUN that cycle.
- Output invariant: PC_Write=0 implies IF_ID_Write=0. Flush and Write may both be 1; flush has priority in the IF/ID register.
- Reset mid-operation: any state returns to RUN next edge and counters clear. mdu_err clears only on reset.
- Rd==0 never causes a stall.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- When defined, adds outputs:
  - perf_stall_cyc [31:0]: cycles with PC_Write==0.
  - perf_flush_cnt [31:0]: cycles with IF_ID_Flush==1.
  - perf_lu_cnt [31:0]: load-use events.
- Counters wrap at 2^32 and clear on reset.
- When undefined, the ports and logic are absent; core behaviour is identical.

Decomposition:
- Shared package hazard_pkg:
  - state enum (RUN, LOAD_USE, MDU_WAIT, MEM_WAIT).
  - REG_X0=5'd0 constant.
  - typedef for the control bundle struct {pc_we, ifid_we, ifid_flush, idex_flush, hold}.
- One sub-module: hazard_perf_cnt, instantiated only under HAZARD_PERF_CNT_EN.

Test Plan:
- Load-use: lw x5 in EX (ID_EX_MemRead=1, Rd=5), ID_RS1=5, use_rs1=1 -> PC_Write=0, IF_ID_Write=0, ID_EX_Flush=1 for exactly 1 cycle, then all released.
- Rd zero: same as above with Rd=0 -> no stall.
- Branch plus load-use in the same cycle -> IF_ID_Flush=1, ID_EX_Flush=1, PC_Write=1, no stall in the following cycle.
- MUL/DIV: EX_muldiv_start, muldiv_done asserted 5 cycles later -> Pipe_Hold=1 for 5 cycles, released on the done cycle, mdu_err=0.
- MUL/DIV timeout: start with no done -> release after 64 cycles, mdu_err=1 sticky until rst=0.
- Memory stall and reset: DM_stall held 3 cycles -> hold for 3 cycles; assert rst=0 during MDU_WAIT -> next cycle RUN, PC_Write=1, all perf counters 0 (if enabled).
